// File: rtl/display_pkg.sv
// Shared types and helpers for the seven-segment scan controller.
//
// Contents:
//   scan_state_t  - scheduler state (IDLE, BLANK, DRIVE)
//   nibble_t      - one hex digit value
//   next_idx_t    - result of the circular enabled-digit search
//   next_enabled  - finds the next enabled digit after idx, circularly,
//                   and flags whether the search wrapped (a frame boundary)
package display_pkg;

    // Upper bound on digits the search helper can handle.
    localparam int MAX_DIGITS = 16;
    localparam int IDX_W      = 4;
    localparam int CNT_W      = IDX_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        DRIVE
    } scan_state_t;

    typedef logic [3:0] nibble_t;

    typedef struct packed {
        logic             found;
        logic             wrap;
        logic [IDX_W-1:0] idx;
    } next_idx_t;

    // Offsets 1..num are tried in order, so the current digit itself is the
    // last candidate; with a single enabled digit it returns itself and wraps.
    function automatic next_idx_t next_enabled(
        input logic [MAX_DIGITS-1:0] en,
        input logic [IDX_W-1:0]      idx,
        input logic [CNT_W-1:0]      num
    );
        next_idx_t        r;
        logic [CNT_W-1:0] cand;
        r = '0;
        for (int k = 1; k <= MAX_DIGITS; k++) begin
            cand = {1'b0, idx} + CNT_W'(k);
            if (cand >= num) begin
                cand = cand - num;
            end
            if (!r.found && (CNT_W'(k) <= num) && en[cand[IDX_W-1:0]]) begin
                r.found = 1'b1;
                r.idx   = cand[IDX_W-1:0];
                r.wrap  = (cand[IDX_W-1:0] <= idx);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/display_scan_timer.sv
// Dwell/blank interval timer for the scan controller.
//
// Ports:
//   clk, reset  - clock, synchronous active-low reset
//   clear       - restart counting from zero on the next edge
//   last_count  - terminal count minus one (the final count value)
//   done        - high while the count sits at last_count
//
// The count saturates at last_count so it never wraps past terminal.
module scan_timer #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [WIDTH-1:0] last_count,
    output logic             done
);

    logic [WIDTH-1:0] count_q, count_d;

    assign done = (count_q == last_count);

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (!done) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexing scheduler for a common-anode seven-segment display.
// Picks one enabled digit at a time, shows its nibble on hex_out, blanks all
// anodes for BLANK_CYCLES, then drives that digit's anode for DWELL_CYCLES.
// Display values are double-buffered: loads while scanning land in a staging
// buffer that is committed to the shadow buffer only at a frame wrap.
//
// Ports:
//   clk, reset  - clock, synchronous active-low reset
//   digit_en    - per-digit enable, disabled digits are skipped
//   digit_val   - nibble per digit, digit i at [4i+3:4i]
//   load        - capture digit_val (direct to shadow in IDLE, else staged)
//   hex_out     - nibble for the shared decoder
//   anode_n     - active-low anode drives, at most one low
//   scan_idx    - index of the current digit
//   frame_done  - one-cycle pulse after each frame wrap
//
// Supports up to display_pkg::MAX_DIGITS digits.
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int NUM_DIGITS   = 2,
    parameter int DWELL_CYCLES = 10000,
    parameter int BLANK_CYCLES = 200,
    localparam int SCAN_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic [4*NUM_DIGITS-1:0] digit_val,
    input  logic                    load,
    output logic [3:0]              hex_out,
    output logic [NUM_DIGITS-1:0]   anode_n,
    output logic [SCAN_W-1:0]       scan_idx,
    output logic                    frame_done
);

    localparam int MAX_CNT = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int TMR_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

    scan_state_t             state_q, state_d;
    logic [SCAN_W-1:0]       scan_idx_q, scan_idx_d;
    logic [NUM_DIGITS-1:0]   anode_n_q, anode_n_d;
    nibble_t                 hex_out_q, hex_out_d;
    logic                    frame_done_q, frame_done_d;
    logic [4*NUM_DIGITS-1:0] staging_q, staging_d;
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic                    pend_q, pend_d;

    logic                    tmr_clear;
    logic                    tmr_done;
    logic [TMR_W-1:0]        tmr_last;
    logic                    advance;
    logic [MAX_DIGITS-1:0]   en_ext;
    logic [IDX_W-1:0]        search_from;
    next_idx_t               nxt;

    assign en_ext = MAX_DIGITS'(digit_en);

    // Searching from the last digit in IDLE yields the lowest enabled index,
    // so one search instance serves both the start-up and advance cases.
    assign search_from = (state_q == IDLE) ? IDX_W'(NUM_DIGITS - 1) : IDX_W'(scan_idx_q);
    assign nxt         = next_enabled(en_ext, search_from, CNT_W'(NUM_DIGITS));

    assign tmr_last = (state_q == DRIVE) ? TMR_W'(DWELL_CYCLES - 1) : TMR_W'(BLANK_CYCLES - 1);

    scan_timer #(
        .WIDTH(TMR_W)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .clear     (tmr_clear),
        .last_count(tmr_last),
        .done      (tmr_done)
    );

    // Next-state and registered-output logic. Outputs are computed from the
    // next state so anodes and hex_out change on the same edge as the state.
    always_comb begin
        state_d      = state_q;
        scan_idx_d   = scan_idx_q;
        staging_d    = staging_q;
        shadow_d     = shadow_q;
        pend_d       = pend_q;
        frame_done_d = 1'b0;
        hex_out_d    = hex_out_q;
        anode_n_d    = '1;
        tmr_clear    = 1'b0;
        advance      = 1'b0;

        case (state_q)
            IDLE: begin
                tmr_clear = 1'b1;
                if (load) begin
                    shadow_d = digit_val;
                end
                if (|digit_en) begin
                    state_d    = BLANK;
                    scan_idx_d = SCAN_W'(nxt.idx);
                end
            end
            BLANK: begin
                // A disabled current digit aborts ahead of the timer.
                if (!digit_en[scan_idx_q]) begin
                    advance = 1'b1;
                end else if (tmr_done) begin
                    state_d   = DRIVE;
                    tmr_clear = 1'b1;
                end
            end
            DRIVE: begin
                if (!digit_en[scan_idx_q] || tmr_done) begin
                    advance = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if ((state_q != IDLE) && load) begin
            staging_d = digit_val;
            pend_d    = 1'b1;
        end

        // A wrap is a frame boundary: commit the pending update, with a
        // same-cycle load taking priority over the staged value.
        if (advance) begin
            tmr_clear = 1'b1;
            if (!nxt.found) begin
                state_d = IDLE;
            end else begin
                state_d    = BLANK;
                scan_idx_d = SCAN_W'(nxt.idx);
                if (nxt.wrap) begin
                    frame_done_d = 1'b1;
                    if (load) begin
                        shadow_d = digit_val;
                    end else if (pend_q) begin
                        shadow_d = staging_q;
                    end
                    pend_d = 1'b0;
                end
            end
        end

        if (state_d != IDLE) begin
            hex_out_d = shadow_d[{scan_idx_d, 2'b00} +: 4];
        end
        if (state_d == DRIVE) begin
            anode_n_d[scan_idx_d] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            scan_idx_q   <= '0;
            anode_n_q    <= '1;
            hex_out_q    <= '0;
            frame_done_q <= 1'b0;
            staging_q    <= '0;
            shadow_q     <= '0;
            pend_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            scan_idx_q   <= scan_idx_d;
            anode_n_q    <= anode_n_d;
            hex_out_q    <= hex_out_d;
            frame_done_q <= frame_done_d;
            staging_q    <= staging_d;
            shadow_q     <= shadow_d;
            pend_q       <= pend_d;
        end
    end

    assign hex_out    = hex_out_q;
    assign anode_n    = anode_n_q;
    assign scan_idx   = scan_idx_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl. Runs a 2-digit and a 4-digit
// instance side by side from shared load/value/reset inputs, and compares
// every cycle against a behavioural model of the scan rules.
module tb_display_scan_ctrl;

    localparam int DWELL = 4;
    localparam int BLANK = 2;

    logic        clk;
    logic        reset;
    logic [1:0]  en2;
    logic [3:0]  en4;
    logic        load;
    logic [15:0] val;

    logic [3:0]  hex2, hex4;
    logic [1:0]  an2;
    logic [3:0]  an4;
    logic [0:0]  scan2;
    logic [1:0]  scan4;
    logic        fd2, fd4;

    int errors = 0;
    int checks = 0;

    // Model state, index 0 = 2-digit instance, index 1 = 4-digit instance.
    int nd[2] = '{2, 4};
    bit mActive[2];
    bit mDrive[2];
    bit mFd[2];
    bit mPend[2];
    bit mHexKnown[2];
    int mCur[2];
    int mLeft[2];
    int mHex[2];
    int mShadow[2][4];
    int mStaging[2][4];

    display_scan_ctrl #(
        .NUM_DIGITS  (2),
        .DWELL_CYCLES(DWELL),
        .BLANK_CYCLES(BLANK)
    ) dut2 (
        .clk       (clk),
        .reset     (reset),
        .digit_en  (en2),
        .digit_val (val[7:0]),
        .load      (load),
        .hex_out   (hex2),
        .anode_n   (an2),
        .scan_idx  (scan2),
        .frame_done(fd2)
    );

    display_scan_ctrl #(
        .NUM_DIGITS  (4),
        .DWELL_CYCLES(DWELL),
        .BLANK_CYCLES(BLANK)
    ) dut4 (
        .clk       (clk),
        .reset     (reset),
        .digit_en  (en4),
        .digit_val (val),
        .load      (load),
        .hex_out   (hex4),
        .anode_n   (an4),
        .scan_idx  (scan4),
        .frame_done(fd4)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish, got hang expected finish");
        $fatal(1, "[TB] timeout");
    end

    // Circular search for the next enabled digit after 'from'; -1 if none.
    function automatic int findNext(int m, int en, int from);
        for (int k = 1; k <= nd[m]; k++) begin
            int c;
            c = (from + k) % nd[m];
            if (((en >> c) & 1) == 1) return c;
        end
        return -1;
    endfunction

    // Advance the model by one clock edge, using the inputs seen at that edge.
    task automatic modelStep(int m, int en, bit rst, bit ld, logic [15:0] v);
        int  nv[4];
        int  c;
        bit  leave;
        for (int i = 0; i < 4; i++) nv[i] = int'((v >> (4 * i)) & 16'hF);
        mFd[m] = 1'b0;
        if (rst) begin
            mActive[m]   = 1'b0;
            mDrive[m]    = 1'b0;
            mPend[m]     = 1'b0;
            mCur[m]      = 0;
            mLeft[m]     = 0;
            mHex[m]      = 0;
            mHexKnown[m] = 1'b1;
            for (int i = 0; i < 4; i++) begin
                mShadow[m][i]  = 0;
                mStaging[m][i] = 0;
            end
            return;
        end
        if (!mActive[m]) begin
            if (ld) for (int i = 0; i < 4; i++) mShadow[m][i] = nv[i];
            if ((en & ((1 << nd[m]) - 1)) != 0) begin
                mActive[m] = 1'b1;
                mDrive[m]  = 1'b0;
                mCur[m]    = findNext(m, en, nd[m] - 1);
                mLeft[m]   = BLANK;
            end
        end else begin
            leave = (((en >> mCur[m]) & 1) == 0) || (mDrive[m] && mLeft[m] == 1);
            if (!leave) begin
                if (!mDrive[m] && mLeft[m] == 1) begin
                    mDrive[m] = 1'b1;
                    mLeft[m]  = DWELL;
                end else begin
                    mLeft[m]--;
                end
            end
            if (ld) begin
                for (int i = 0; i < 4; i++) mStaging[m][i] = nv[i];
                mPend[m] = 1'b1;
            end
            if (leave) begin
                c = findNext(m, en, mCur[m]);
                if (c < 0) begin
                    mActive[m] = 1'b0;
                end else begin
                    if (c <= mCur[m]) begin
                        mFd[m] = 1'b1;
                        if (ld) for (int i = 0; i < 4; i++) mShadow[m][i] = nv[i];
                        else if (mPend[m]) for (int i = 0; i < 4; i++) mShadow[m][i] = mStaging[m][i];
                        mPend[m] = 1'b0;
                    end
                    mCur[m]   = c;
                    mDrive[m] = 1'b0;
                    mLeft[m]  = BLANK;
                end
            end
        end
        if (mActive[m]) begin
            mHex[m]      = mShadow[m][mCur[m]];
            mHexKnown[m] = 1'b1;
        end else begin
            mHexKnown[m] = 1'b0;
        end
    endtask

    // Single comparison point: counts and reports mismatches.
    task automatic checkOutput(string tag, logic [31:0] observed, logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Compare both instances against the model.
    task automatic checkAll();
        for (int m = 0; m < 2; m++) begin
            int expAn;
            expAn = (1 << nd[m]) - 1;
            if (mActive[m] && mDrive[m]) expAn = expAn & ~(1 << mCur[m]);
            checkOutput($sformatf("anode_n[%0d]", m), (m == 0) ? 32'(an2) : 32'(an4), 32'(expAn));
            checkOutput($sformatf("frame_done[%0d]", m), (m == 0) ? 32'(fd2) : 32'(fd4), 32'(mFd[m]));
            if (mActive[m])
                checkOutput($sformatf("scan_idx[%0d]", m), (m == 0) ? 32'(scan2) : 32'(scan4), 32'(mCur[m]));
            if (mHexKnown[m])
                checkOutput($sformatf("hex_out[%0d]", m), (m == 0) ? 32'(hex2) : 32'(hex4), 32'(mHex[m]));
        end
    endtask

    // Drive one cycle of inputs, step the model at the edge, check at negedge.
    task automatic applyStimulus(bit rst, logic [1:0] e2, logic [3:0] e4, bit ld, logic [15:0] v);
        reset = ~rst;
        en2   = e2;
        en4   = e4;
        load  = ld;
        val   = v;
        @(posedge clk);
        modelStep(0, int'(e2), rst, ld, v);
        modelStep(1, int'(e4), rst, ld, v);
        @(negedge clk);
        checkAll();
    endtask

    // Run until the 2-digit instance is driving the given digit, bounded.
    task automatic runUntilDrive(int digit, logic [1:0] e2, logic [3:0] e4);
        int n;
        n = 0;
        while (!(mActive[0] && mDrive[0] && mCur[0] == digit) && n < 50) begin
            applyStimulus(1'b0, e2, e4, 1'b0, 16'hC3A5);
            n++;
        end
        checkOutput("reachDrive", 32'(mActive[0] && mDrive[0] && mCur[0] == digit), 32'd1);
    endtask

    // Directed scenarios first, then randomized traffic.
    initial begin
        logic [1:0]  e2r;
        logic [3:0]  e4r;
        logic [15:0] vr;
        bit          ldr;
        bit          rr;

        // Reset held with enables set: everything off.
        repeat (3) applyStimulus(1'b1, 2'b11, 4'b1111, 1'b0, 16'h0000);

        // Load 5/A (and 3/C on the wide instance) in IDLE, then scan.
        applyStimulus(1'b0, 2'b00, 4'b0000, 1'b1, 16'hC3A5);
        repeat (40) applyStimulus(1'b0, 2'b11, 4'b1010, 1'b0, 16'hC3A5);

        // Load during DRIVE of digit 0: no change until the frame wraps.
        runUntilDrive(0, 2'b11, 4'b1010);
        applyStimulus(1'b0, 2'b11, 4'b1010, 1'b0, 16'hC3A5);
        applyStimulus(1'b0, 2'b11, 4'b1010, 1'b1, 16'h1273);
        repeat (30) applyStimulus(1'b0, 2'b11, 4'b1010, 1'b0, 16'h0000);

        // Abort digit 0 mid-drive, then drop everything.
        runUntilDrive(0, 2'b11, 4'b1010);
        applyStimulus(1'b0, 2'b11, 4'b1010, 1'b0, 16'h0000);
        repeat (14) applyStimulus(1'b0, 2'b10, 4'b1000, 1'b0, 16'h0000);
        repeat (4) applyStimulus(1'b0, 2'b00, 4'b0000, 1'b0, 16'h0000);

        // Single enabled digit from IDLE.
        repeat (20) applyStimulus(1'b0, 2'b10, 4'b0100, 1'b0, 16'h0000);

        // Randomized enables, loads and occasional resets.
        e2r = 2'b11;
        e4r = 4'b1111;
        for (int i = 0; i < 700; i++) begin
            if ($urandom_range(0, 24) == 0) e2r = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 24) == 0) e4r = 4'($urandom_range(0, 15));
            ldr = ($urandom_range(0, 7) == 0);
            rr  = ($urandom_range(0, 299) == 0);
            vr  = 16'($urandom);
            applyStimulus(rr, e2r, e4r, ldr, vr);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
